// File: rtl/teatris_fluxo_dados_if.sv
// rtl/teatris_fluxo_dados_if.sv - control/status bundle between the control unit and the teatris datapath
//
// master : control unit side (drives commands, reads status)
// slave  : datapath side (reads commands, drives status)
// Commands : zera_contador, conta_contador, enable_memoria, registra_jogada, zera_jogada,
//            timer_restart, timer_animacao_restart, conta_timer_animacao, conta_erro,
//            zera_erro, sel_peca, mapa_fim (1 bit each), sel_mapa[1:0], botoes[3:0]
// Status   : timeout, fim_sequencia, tem_jogada, jogada_ok, fim_timer_animacao (1 bit each),
//            peca_exibida[3:0], erros[3:0], db_contagem[3:0], db_memoria[3:0], db_jogada[3:0]
interface teatris_fluxo_dados_if;
    logic       zera_contador;
    logic       conta_contador;
    logic       enable_memoria;
    logic       registra_jogada;
    logic       zera_jogada;
    logic       timer_restart;
    logic       timer_animacao_restart;
    logic       conta_timer_animacao;
    logic       conta_erro;
    logic       zera_erro;
    logic       sel_peca;
    logic       mapa_fim;
    logic [1:0] sel_mapa;
    logic [3:0] botoes;

    logic       timeout;
    logic       fim_sequencia;
    logic       tem_jogada;
    logic       jogada_ok;
    logic       fim_timer_animacao;
    logic [3:0] peca_exibida;
    logic [3:0] erros;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_jogada;

    modport master (
        output zera_contador, conta_contador, enable_memoria, registra_jogada, zera_jogada,
               timer_restart, timer_animacao_restart, conta_timer_animacao, conta_erro,
               zera_erro, sel_peca, mapa_fim, sel_mapa, botoes,
        input  timeout, fim_sequencia, tem_jogada, jogada_ok, fim_timer_animacao,
               peca_exibida, erros, db_contagem, db_memoria, db_jogada
    );

    modport slave (
        input  zera_contador, conta_contador, enable_memoria, registra_jogada, zera_jogada,
               timer_restart, timer_animacao_restart, conta_timer_animacao, conta_erro,
               zera_erro, sel_peca, mapa_fim, sel_mapa, botoes,
        output timeout, fim_sequencia, tem_jogada, jogada_ok, fim_timer_animacao,
               peca_exibida, erros, db_contagem, db_memoria, db_jogada
    );
endinterface

// File: rtl/teatris_fluxo_dados.sv
// rtl/teatris_fluxo_dados.sv - teatris datapath: sequence ROM, play capture, timers, error count, display mux
//
// Ports:
//   clock : system clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : teatris_fluxo_dados_if.slave (control commands in, status/debug out)
module teatris_fluxo_dados #(
    parameter int N_JOGADAS      = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int ANIM_CICLOS    = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    teatris_fluxo_dados_if.slave  bus
);

    localparam logic [3:0]  ULTIMO_ENDERECO = 4'(N_JOGADAS - 1);
    localparam logic [15:0] TIMEOUT_MAX     = 16'(TIMEOUT_CICLOS - 1);
    localparam logic [15:0] ANIM_MAX        = 16'(ANIM_CICLOS - 1);

    logic [3:0]  r_contagem;
    logic [3:0]  r_memoria;
    logic [3:0]  r_jogada;
    logic [3:0]  r_sinc1;
    logic [3:0]  r_sinc2;
    logic [3:0]  r_anterior;
    logic [15:0] r_timer;
    logic [15:0] r_timer_anim;
    logic [3:0]  r_erros;

    logic [3:0]  w_rom;
    logic [3:0]  w_peca;

    // Sequence ROM: (3*i + 1) mod 16, the 4-bit width does the modulo.
    assign w_rom = (r_contagem << 1) + r_contagem + 4'd1;

    // Address counter; clear beats increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= 4'd0;
        end else if (bus.zera_contador) begin
            r_contagem <= 4'd0;
        end else if (bus.conta_contador) begin
            r_contagem <= r_contagem + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_memoria <= 4'd0;
        end else if (bus.enable_memoria) begin
            r_memoria <= w_rom;
        end
    end

    // Buttons: two-flop synchronizer, then a previous-value flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sinc1    <= 4'd0;
            r_sinc2    <= 4'd0;
            r_anterior <= 4'd0;
        end else begin
            r_sinc1    <= bus.botoes;
            r_sinc2    <= r_sinc1;
            r_anterior <= r_sinc2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jogada <= 4'd0;
        end else if (bus.zera_jogada) begin
            r_jogada <= 4'd0;
        end else if (bus.registra_jogada) begin
            r_jogada <= r_sinc2;
        end
    end

    // Timeout timer runs freely between restarts and parks at its terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= 16'd0;
        end else if (bus.timer_restart) begin
            r_timer <= 16'd0;
        end else if (r_timer != TIMEOUT_MAX) begin
            r_timer <= r_timer + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer_anim <= 16'd0;
        end else if (bus.timer_animacao_restart) begin
            r_timer_anim <= 16'd0;
        end else if (bus.conta_timer_animacao && (r_timer_anim != ANIM_MAX)) begin
            r_timer_anim <= r_timer_anim + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_erros <= 4'd0;
        end else if (bus.zera_erro) begin
            r_erros <= 4'd0;
        end else if (bus.conta_erro && (r_erros != 4'hF)) begin
            r_erros <= r_erros + 4'd1;
        end
    end

    // Display source: end-of-game map overrides everything.
    always_comb begin
        w_peca = 4'h0;
        if (bus.mapa_fim) begin
            w_peca = 4'hF;
        end else if (!bus.sel_peca) begin
            w_peca = r_memoria;
        end else begin
            case (bus.sel_mapa)
                2'b01:   w_peca = r_memoria;
                2'b11:   w_peca = r_jogada;
                default: w_peca = 4'h0;
            endcase
        end
    end

    // A new press is "something now" after "nothing before"; a change between
    // two nonzero codes is deliberately not a new press.
    assign bus.tem_jogada         = (|r_sinc2) & ~(|r_anterior);
    assign bus.fim_sequencia      = (r_contagem == ULTIMO_ENDERECO);
    assign bus.jogada_ok          = (r_jogada == r_memoria);
    assign bus.timeout            = (r_timer == TIMEOUT_MAX);
    assign bus.fim_timer_animacao = (r_timer_anim == ANIM_MAX);
    assign bus.peca_exibida       = w_peca;
    assign bus.erros              = r_erros;
    assign bus.db_contagem        = r_contagem;
    assign bus.db_memoria         = r_memoria;
    assign bus.db_jogada          = r_jogada;

endmodule

// File: tb/tb_teatris_fluxo_dados.sv
// tb/tb_teatris_fluxo_dados.sv - self-checking bench for teatris_fluxo_dados
module tb_teatris_fluxo_dados;

    localparam int NJ  = 16;
    localparam int TMO = 20;
    localparam int ANI = 8;

    logic clock;
    logic reset;

    teatris_fluxo_dados_if u_if ();

    teatris_fluxo_dados #(
        .N_JOGADAS      (NJ),
        .TIMEOUT_CICLOS (TMO),
        .ANIM_CICLOS    (ANI)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_err;

    // Reference state: plain integers following the written rules.
    int m_addr, m_mem, m_play, m_tmo, m_anim, m_errs;
    int h0, h1, h2;   // button value sampled at the last, 2nd-last, 3rd-last edge

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_mem = 0; m_play = 0; m_tmo = 0; m_anim = 0; m_errs = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            if (u_if.enable_memoria) m_mem = (3 * m_addr + 1) % 16;
            if (u_if.zera_contador) m_addr = 0;
            else if (u_if.conta_contador) m_addr = (m_addr + 1) % 16;
            if (u_if.zera_jogada) m_play = 0;
            else if (u_if.registra_jogada) m_play = h1;
            h2 = h1; h1 = h0; h0 = int'(u_if.botoes);
            if (u_if.timer_restart) m_tmo = 0;
            else if (m_tmo < TMO - 1) m_tmo = m_tmo + 1;
            if (u_if.timer_animacao_restart) m_anim = 0;
            else if (u_if.conta_timer_animacao && m_anim < ANI - 1) m_anim = m_anim + 1;
            if (u_if.zera_erro) m_errs = 0;
            else if (u_if.conta_erro && m_errs < 15) m_errs = m_errs + 1;
        end
    endtask

    function automatic int exp_peca();
        if (u_if.mapa_fim) return 15;
        if (!u_if.sel_peca) return m_mem;
        if (u_if.sel_mapa == 2'b01) return m_mem;
        if (u_if.sel_mapa == 2'b11) return m_play;
        return 0;
    endfunction

    task automatic check_all();
        chk("db_contagem",   16'(u_if.db_contagem),        16'(m_addr));
        chk("db_memoria",    16'(u_if.db_memoria),         16'(m_mem));
        chk("db_jogada",     16'(u_if.db_jogada),          16'(m_play));
        chk("erros",         16'(u_if.erros),              16'(m_errs));
        chk("fim_sequencia", 16'(u_if.fim_sequencia),      16'(m_addr == NJ - 1));
        chk("jogada_ok",     16'(u_if.jogada_ok),          16'(m_play == m_mem));
        chk("tem_jogada",    16'(u_if.tem_jogada),         16'(h1 != 0 && h2 == 0));
        chk("timeout",       16'(u_if.timeout),            16'(m_tmo == TMO - 1));
        chk("fim_anim",      16'(u_if.fim_timer_animacao), 16'(m_anim == ANI - 1));
        chk("peca_exibida",  16'(u_if.peca_exibida),       16'(exp_peca()));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic idle();
        u_if.zera_contador = 0; u_if.conta_contador = 0; u_if.enable_memoria = 0;
        u_if.registra_jogada = 0; u_if.zera_jogada = 0; u_if.timer_restart = 0;
        u_if.timer_animacao_restart = 0; u_if.conta_timer_animacao = 0;
        u_if.conta_erro = 0; u_if.zera_erro = 0; u_if.sel_peca = 0; u_if.mapa_fim = 0;
        u_if.sel_mapa = 2'b00; u_if.botoes = 4'h0;
    endtask

    initial begin
        int pulses;
        int pulse_at;
        int rise_at;
        n_vec = 0;
        n_err = 0;
        idle();
        model_reset();

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all();
        chk("rst_jogada_ok", 16'(u_if.jogada_ok), 16'd1);
        chk("rst_fim_seq",   16'(u_if.fim_sequencia), 16'd0);
        chk("rst_peca",      16'(u_if.peca_exibida), 16'd0);
        reset = 1'b0;
        tick();

        // Address walk through the ROM
        u_if.zera_contador = 1; tick(); u_if.zera_contador = 0;
        u_if.conta_contador = 1; u_if.enable_memoria = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("walk_mem", 16'(u_if.db_memoria), 16'((3 * i + 1) % 16));
            chk("walk_fim", 16'(u_if.fim_sequencia), 16'(i == 14));
        end
        chk("walk_wrap", 16'(u_if.db_contagem), 16'd0);
        u_if.enable_memoria = 0;
        tick();                                  // address 1
        u_if.conta_contador = 0; u_if.enable_memoria = 1;
        tick();                                  // memory = ROM[1] = 4
        u_if.enable_memoria = 0;
        chk("walk_rom1", 16'(u_if.db_memoria), 16'd4);

        // Single press held for 10 cycles
        u_if.botoes = 4'h4;
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (u_if.tem_jogada) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        chk("press_pulses", 16'(pulses), 16'd1);
        chk("press_latency", 16'(pulse_at), 16'd2);
        u_if.registra_jogada = 1; tick(); u_if.registra_jogada = 0;
        chk("press_jogada", 16'(u_if.db_jogada), 16'd4);
        chk("press_ok", 16'(u_if.jogada_ok), 16'd1);
        u_if.botoes = 4'h2; tick(); tick(); tick();   // nonzero to different nonzero
        u_if.botoes = 4'h0; tick(); tick(); tick();

        // Timeout timer
        u_if.timer_restart = 1; tick(); u_if.timer_restart = 0;
        rise_at = -1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (u_if.timeout && rise_at < 0) rise_at = k;
        end
        chk("timeout_rise", 16'(rise_at + 1), 16'(TMO));
        chk("timeout_hold", 16'(u_if.timeout), 16'd1);
        u_if.timer_restart = 1; tick(); u_if.timer_restart = 0;
        chk("timeout_clear", 16'(u_if.timeout), 16'd0);

        // Animation timer
        u_if.timer_animacao_restart = 1; tick(); u_if.timer_animacao_restart = 0;
        u_if.conta_timer_animacao = 1;
        rise_at = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (u_if.fim_timer_animacao && rise_at < 0) rise_at = k;
        end
        chk("anim_rise", 16'(rise_at), 16'(ANI - 1));
        u_if.timer_animacao_restart = 1; tick(); u_if.timer_animacao_restart = 0;
        chk("anim_restart_prio", 16'(u_if.fim_timer_animacao), 16'd0);
        u_if.conta_timer_animacao = 0;

        // Error counter
        u_if.conta_erro = 1;
        repeat (20) tick();
        chk("erros_sat", 16'(u_if.erros), 16'd15);
        u_if.zera_erro = 1; tick(); u_if.zera_erro = 0; u_if.conta_erro = 0;
        chk("erros_clear_prio", 16'(u_if.erros), 16'd0);

        // Display mux (combinational)
        u_if.mapa_fim = 1; u_if.sel_peca = 1; u_if.sel_mapa = 2'b11; #1;
        check_all();
        chk("disp_fim", 16'(u_if.peca_exibida), 16'hF);
        u_if.mapa_fim = 0; #1;
        check_all();
        chk("disp_jogada", 16'(u_if.peca_exibida), 16'd4);
        u_if.sel_mapa = 2'b10; #1;
        check_all();
        chk("disp_zero", 16'(u_if.peca_exibida), 16'd0);
        idle();
        tick();

        // Reset mid-press and mid-count, button held across release
        u_if.botoes = 4'h8; u_if.conta_contador = 1; u_if.conta_erro = 1;
        tick(); tick();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        tick(); tick();
        reset = 1'b0;
        u_if.conta_contador = 0; u_if.conta_erro = 0;
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (u_if.tem_jogada) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        chk("rst_press_pulses", 16'(pulses), 16'd1);
        chk("rst_press_latency", 16'(pulse_at), 16'd2);
        idle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if (reset) reset = 1'b0;
            u_if.zera_contador          = ($urandom_range(0, 15) == 0);
            u_if.conta_contador         = ($urandom_range(0, 2) == 0);
            u_if.enable_memoria         = ($urandom_range(0, 1) == 0);
            u_if.registra_jogada        = ($urandom_range(0, 3) == 0);
            u_if.zera_jogada            = ($urandom_range(0, 15) == 0);
            u_if.timer_restart          = ($urandom_range(0, 40) == 0);
            u_if.timer_animacao_restart = ($urandom_range(0, 20) == 0);
            u_if.conta_timer_animacao   = ($urandom_range(0, 1) == 0);
            u_if.conta_erro             = ($urandom_range(0, 3) == 0);
            u_if.zera_erro              = ($urandom_range(0, 30) == 0);
            u_if.sel_peca               = 1'($urandom_range(0, 1));
            u_if.mapa_fim               = ($urandom_range(0, 7) == 0);
            u_if.sel_mapa               = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) u_if.botoes = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1 model_reset();
                check_all();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
